// File: rtl/uart_ddr_cmd_ctrl_pkg.sv
// Shared constants for the UART-to-MCB command sequencer: frame opcodes, reply bytes,
// MCB instruction codes and the controller state encoding.
package uart_ddr_cmd_ctrl_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RPL_ERR  = 8'h45;
  localparam logic [7:0] RPL_OK   = 8'h4B;
  localparam logic [7:0] RPL_TMO  = 8'h54;

  localparam logic [2:0] INSTR_WRITE = 3'b000;
  localparam logic [2:0] INSTR_READ  = 3'b001;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WPUSH,
    ST_WCMD,
    ST_RCMD,
    ST_RWAIT,
    ST_RSEND,
    ST_REPLY
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_ddr_cmd_ctrl_if.sv
// UART byte link plus MCB port-0 command/write/read channels as seen by the sequencer.
interface uart_ddr_cmd_ctrl_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 30
);
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                p0_cmd_en;
  logic [2:0]          p0_cmd_instr;
  logic [5:0]          p0_cmd_bl;
  logic [ADDR_W-1:0]   p0_cmd_byte_addr;
  logic                p0_cmd_full;
  logic                p0_wr_en;
  logic [DATA_W-1:0]   p0_wr_data;
  logic [DATA_W/8-1:0] p0_wr_mask;
  logic                p0_wr_full;
  logic                p0_rd_en;
  logic [DATA_W-1:0]   p0_rd_data;
  logic                p0_rd_empty;

  modport master (
    input  rx_data, rx_valid, tx_ready, p0_cmd_full, p0_wr_full, p0_rd_data, p0_rd_empty,
    output rx_ready, tx_data, tx_valid, p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
           p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, p0_cmd_full, p0_wr_full, p0_rd_data, p0_rd_empty,
    input  rx_ready, tx_data, tx_valid, p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
           p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en
  );
endinterface

// File: rtl/uart_ddr_cmd_ctrl.sv
// Parses single-word read/write frames from the UART, drives MCB port 0 and
// answers with the read word or a one-byte status (K / E / T).
module uart_ddr_cmd_ctrl
  import uart_ddr_cmd_ctrl_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 1023
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic                calib_done,
  uart_ddr_cmd_ctrl_if.master bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BW     = $clog2(NBYTES);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_is_write;
  logic [BW-1:0]       r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;
  logic [TMO_W-1:0]    r_tmo;

  logic                w_rx_ready;
  logic                w_wr_en;
  logic                w_cmd_en;
  logic                w_rd_en;
  logic [2:0]          w_cmd_instr;
  logic                w_rx_acc;
  logic                w_tx_acc;
  logic                w_cnt_last;

  assign w_rx_acc   = bus.rx_valid & w_rx_ready;
  assign w_tx_acc   = r_tx_valid & bus.tx_ready;
  assign w_cnt_last = (r_cnt == BW'(NBYTES - 1));

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rx_ready  = 1'b0;
    w_wr_en     = 1'b0;
    w_cmd_en    = 1'b0;
    w_rd_en     = 1'b0;
    w_cmd_instr = INSTR_WRITE;
    case (r_state)
      ST_IDLE: begin
        // calib_done only gates new opcodes; a started frame runs to completion
        w_rx_ready = calib_done;
        w_rd_en    = ~bus.p0_rd_empty;
        if (calib_done && bus.rx_valid)
          w_state_nxt = is_opcode(bus.rx_data) ? ST_ADDR : ST_REPLY;
      end
      ST_ADDR: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid && r_cnt == BW'(3))
          w_state_nxt = r_is_write ? ST_WDATA : ST_RCMD;
      end
      ST_WDATA: begin
        w_rx_ready = 1'b1;
        if (bus.rx_valid && w_cnt_last) w_state_nxt = ST_WPUSH;
      end
      ST_WPUSH: begin
        if (!bus.p0_wr_full) begin
          w_wr_en     = 1'b1;
          w_state_nxt = ST_WCMD;
        end
      end
      ST_WCMD: begin
        if (!bus.p0_cmd_full) begin
          w_cmd_en    = 1'b1;
          w_state_nxt = ST_REPLY;
        end
      end
      ST_RCMD: begin
        w_cmd_instr = INSTR_READ;
        if (!bus.p0_cmd_full) begin
          w_cmd_en    = 1'b1;
          w_state_nxt = ST_RWAIT;
        end
      end
      ST_RWAIT: begin
        if (!bus.p0_rd_empty) begin
          w_rd_en     = 1'b1;
          w_state_nxt = ST_RSEND;
        end else if (r_tmo == '0) begin
          w_state_nxt = ST_REPLY;
        end
      end
      ST_RSEND: if (w_tx_acc && w_cnt_last) w_state_nxt = ST_IDLE;
      ST_REPLY: if (w_tx_acc) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (sys_rst_i) begin
      w_rx_ready  = 1'b0;
      w_wr_en     = 1'b0;
      w_cmd_en    = 1'b0;
      w_rd_en     = 1'b0;
      w_cmd_instr = INSTR_WRITE;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_is_write <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tmo      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_rx_acc) begin
          r_is_write <= (bus.rx_data == OP_WRITE);
          r_cnt      <= '0;
          if (!is_opcode(bus.rx_data)) begin
            r_tx_data  <= RPL_ERR;
            r_tx_valid <= 1'b1;
          end
        end
        ST_ADDR: if (w_rx_acc) begin
          r_addr <= {r_addr[ADDR_W-9:0], bus.rx_data};
          r_cnt  <= (r_cnt == BW'(3)) ? '0 : r_cnt + 1'b1;
        end
        ST_WDATA: if (w_rx_acc) begin
          r_wdata <= {r_wdata[DATA_W-9:0], bus.rx_data};
          r_cnt   <= w_cnt_last ? '0 : r_cnt + 1'b1;
        end
        ST_WCMD: if (w_cmd_en) begin
          r_tx_data  <= RPL_OK;
          r_tx_valid <= 1'b1;
        end
        ST_RCMD: if (w_cmd_en) r_tmo <= TMO_W'(TIMEOUT - 1);
        ST_RWAIT: begin
          if (w_rd_en) begin
            r_tx_data  <= bus.p0_rd_data[DATA_W-1 -: 8];
            r_rdata    <= bus.p0_rd_data << 8;
            r_tx_valid <= 1'b1;
            r_cnt      <= '0;
          end else if (r_tmo == '0) begin
            r_tx_data  <= RPL_TMO;
            r_tx_valid <= 1'b1;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        ST_RSEND: if (w_tx_acc) begin
          if (w_cnt_last) begin
            r_tx_valid <= 1'b0;
            r_cnt      <= '0;
          end else begin
            r_tx_data <= r_rdata[DATA_W-1 -: 8];
            r_rdata   <= r_rdata << 8;
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        ST_REPLY: if (w_tx_acc) r_tx_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready         = w_rx_ready;
  assign bus.tx_data          = r_tx_data;
  assign bus.tx_valid         = r_tx_valid;
  assign bus.p0_cmd_en        = w_cmd_en;
  assign bus.p0_cmd_instr     = w_cmd_instr;
  assign bus.p0_cmd_bl        = '0;
  assign bus.p0_cmd_byte_addr = {r_addr[ADDR_W-1:BW], {BW{1'b0}}};
  assign bus.p0_wr_en         = w_wr_en;
  assign bus.p0_wr_data       = r_wdata;
  assign bus.p0_wr_mask       = '0;
  assign bus.p0_rd_en         = w_rd_en;

endmodule

// File: tb/tb_uart_ddr_cmd_ctrl.sv
// Directed bench for uart_ddr_cmd_ctrl: UART frames in, MCB port-0 model and reply collector out.
module tb_uart_ddr_cmd_ctrl;
  import uart_ddr_cmd_ctrl_pkg::*;

  localparam int TIMEOUT = 1023;

  logic clk = 1'b0;
  logic rst;
  logic calib_done;
  always #5 clk = ~clk;

  uart_ddr_cmd_ctrl_if #(.DATA_W(128), .ADDR_W(30)) u_if ();

  uart_ddr_cmd_ctrl #(.DATA_W(128), .ADDR_W(30), .TIMEOUT(TIMEOUT)) u_dut (
    .sys_clk_i  (clk),
    .sys_rst_i  (rst),
    .calib_done (calib_done),
    .bus        (u_if)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_wr = 0, n_cmd = 0, n_rd = 0, n_rxrdy = 0;
  int wr_cyc = 0, cmd_cyc = 0, tx_rise_cyc = 0;
  logic [127:0] last_wr_data;
  logic [15:0]  last_wr_mask;
  logic [2:0]   last_instr;
  logic [29:0]  last_addr;
  logic [5:0]   last_bl;
  logic [7:0]   txq[$];
  logic         prev_txv = 1'b0;
  logic         rd_auto = 1'b1;
  logic [127:0] rd_word = '0;
  int           rd_delay = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tx_byte(input int i);
    if (i < txq.size()) return txq[i];
    return 8'hxx;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (u_if.p0_wr_en) begin
      n_wr++; wr_cyc = cyc;
      last_wr_data = u_if.p0_wr_data; last_wr_mask = u_if.p0_wr_mask;
    end
    if (u_if.p0_cmd_en) begin
      n_cmd++; cmd_cyc = cyc;
      last_instr = u_if.p0_cmd_instr; last_addr = u_if.p0_cmd_byte_addr; last_bl = u_if.p0_cmd_bl;
    end
    if (u_if.p0_rd_en) n_rd++;
    if (u_if.rx_ready) n_rxrdy++;
    if (u_if.tx_valid && u_if.tx_ready) txq.push_back(u_if.tx_data);
    if (u_if.tx_valid && !prev_txv) tx_rise_cyc = cyc;
    prev_txv = u_if.tx_valid;
  end

  // Read FIFO model: word appears 5 cycles after a read command, leaves on p0_rd_en.
  initial begin
    logic take, arm;
    u_if.p0_rd_empty = 1'b1;
    u_if.p0_rd_data  = '0;
    forever begin
      @(negedge clk);
      take = u_if.p0_rd_en;
      arm  = u_if.p0_cmd_en && (u_if.p0_cmd_instr == INSTR_READ) && rd_auto;
      @(posedge clk); #1;
      if (take) u_if.p0_rd_empty = 1'b1;
      if (arm) rd_delay = 5;
      else if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          u_if.p0_rd_empty = 1'b0;
          u_if.p0_rd_data  = rd_word;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    u_if.rx_data = b; u_if.rx_valid = 1'b1;
    @(negedge clk);
    while (!u_if.rx_ready && n < 50) begin @(negedge clk); n++; end
    if (!u_if.rx_ready) check_eq("rx_accept", 128'(u_if.rx_ready), 128'd1);
    @(posedge clk); #1;
    u_if.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [127:0] d,
                            input logic drop_calib);
    send_byte(op);
    if (drop_calib) calib_done = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8]);
    if (op == OP_WRITE)
      for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8]);
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (txq.size() < n && k < budget) begin @(posedge clk); k++; end
    #1;
    check_eq(tag, 128'(txq.size()), 128'(n));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int w0, c0, r0, x0, acc, drop;
    logic [127:0] got;
    rst = 1'b1; calib_done = 1'b1;
    u_if.rx_data = '0; u_if.rx_valid = 1'b0; u_if.tx_ready = 1'b1;
    u_if.p0_cmd_full = 1'b0; u_if.p0_wr_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rx_ready", 128'(u_if.rx_ready), 128'd0);
    check_eq("rst_tx_valid", 128'(u_if.tx_valid), 128'd0);
    check_eq("rst_tx_data", 128'(u_if.tx_data), 128'd0);
    check_eq("rst_mcb_en", 128'({u_if.p0_cmd_en, u_if.p0_wr_en, u_if.p0_rd_en}), 128'd0);
    check_eq("rst_cmd_addr", 128'(u_if.p0_cmd_byte_addr), 128'd0);
    check_eq("rst_wr_data", u_if.p0_wr_data, 128'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Write: addr 0x123 -> 0x120, latency wr -> cmd -> K on consecutive cycles
    txq.delete(); w0 = n_wr; c0 = n_cmd;
    send_frame(OP_WRITE, 32'h0000_0123, 128'h000102030405060708090A0B0C0D0E0F, 1'b0);
    acc = cyc;
    wait_tx(1, 20, "w1_tx_cnt");
    check_eq("w1_wr_cnt", 128'(n_wr - w0), 128'd1);
    check_eq("w1_cmd_cnt", 128'(n_cmd - c0), 128'd1);
    check_eq("w1_wr_data", last_wr_data, 128'h000102030405060708090A0B0C0D0E0F);
    check_eq("w1_wr_mask", 128'(last_wr_mask), 128'd0);
    check_eq("w1_instr", 128'(last_instr), 128'(INSTR_WRITE));
    check_eq("w1_addr", 128'(last_addr), 128'h120);
    check_eq("w1_bl", 128'(last_bl), 128'd0);
    check_eq("w1_wr_lat", 128'(wr_cyc - acc), 128'd0);
    check_eq("w1_cmd_lat", 128'(cmd_cyc - acc), 128'd1);
    check_eq("w1_tx_lat", 128'(tx_rise_cyc - acc), 128'd2);
    check_eq("w1_reply", 128'(tx_byte(0)), 128'h4B);

    // Read back the same word
    txq.delete(); r0 = n_rd; rd_auto = 1'b1;
    rd_word = 128'h000102030405060708090A0B0C0D0E0F;
    send_frame(OP_READ, 32'h0000_0120, '0, 1'b0);
    wait_tx(16, 80, "r1_tx_cnt");
    got = '0;
    for (int i = 0; i < 16; i++) got = {got[119:0], tx_byte(i)};
    check_eq("r1_bytes", got, 128'h000102030405060708090A0B0C0D0E0F);
    check_eq("r1_instr", 128'(last_instr), 128'(INSTR_READ));
    check_eq("r1_addr", 128'(last_addr), 128'h120);
    check_eq("r1_rd_cnt", 128'(n_rd - r0), 128'd1);

    // Bad opcode: E, no MCB traffic
    txq.delete(); w0 = n_wr; c0 = n_cmd; r0 = n_rd;
    send_byte(8'h41);
    wait_tx(1, 10, "bad_tx_cnt");
    check_eq("bad_reply", 128'(tx_byte(0)), 128'h45);
    check_eq("bad_mcb", 128'((n_wr - w0) + (n_cmd - c0) + (n_rd - r0)), 128'd0);

    // Write with command FIFO full for 20 cycles
    txq.delete(); w0 = n_wr; c0 = n_cmd;
    send_frame(OP_WRITE, 32'h0000_0ABC, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF, 1'b0);
    u_if.p0_cmd_full = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("full_hold_cmd", 128'(n_cmd - c0), 128'd0);
    check_eq("full_wr_cnt", 128'(n_wr - w0), 128'd1);
    u_if.p0_cmd_full = 1'b0; drop = cyc;
    wait_tx(1, 10, "full_tx_cnt");
    check_eq("full_cmd_cyc", 128'(cmd_cyc - drop), 128'd0);
    check_eq("full_cmd_cnt", 128'(n_cmd - c0), 128'd1);
    check_eq("full_addr", 128'(last_addr), 128'hAB0);
    check_eq("full_wr_data", last_wr_data, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    check_eq("full_reply", 128'(tx_byte(0)), 128'h4B);

    // Read with tx_ready stalled 10 cycles after the third byte
    txq.delete(); rd_word = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;
    send_frame(OP_READ, 32'h0000_0ABC, '0, 1'b0);
    wait_tx(3, 40, "stall_pre_cnt");
    u_if.tx_ready = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("stall_hold", 128'({u_if.tx_valid, u_if.tx_data}), 128'h1F3);
    check_eq("stall_qsize", 128'(txq.size()), 128'd3);
    @(posedge clk); #1 u_if.tx_ready = 1'b1;
    wait_tx(16, 40, "stall_tx_cnt");
    got = '0;
    for (int i = 0; i < 16; i++) got = {got[119:0], tx_byte(i)};
    check_eq("stall_bytes", got, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);
    check_eq("stall_addr", 128'(last_addr), 128'hAB0);

    // Read timeout: T registered TIMEOUT edges after the command edge
    txq.delete(); rd_auto = 1'b0; r0 = n_rd;
    send_frame(OP_READ, 32'h0000_0200, '0, 1'b0);
    wait_tx(1, TIMEOUT + 60, "tmo_tx_cnt");
    check_eq("tmo_reply", 128'(tx_byte(0)), 128'h54);
    check_eq("tmo_lat", 128'(tx_rise_cyc - cmd_cyc), 128'(TIMEOUT + 1));
    check_eq("tmo_no_rd", 128'(n_rd - r0), 128'd0);
    rd_word = 128'hDEAD_BEEF_0000_0000_0000_0000_CAFE_F00D;
    rd_delay = 2;
    repeat (8) @(posedge clk);
    #1;
    check_eq("late_drain", 128'(n_rd - r0), 128'd1);
    check_eq("late_no_tx", 128'(txq.size()), 128'd1);
    rd_auto = 1'b1;

    // calib_done low: opcode never accepted
    calib_done = 1'b0; x0 = n_rxrdy; c0 = n_cmd;
    u_if.rx_data = OP_WRITE; u_if.rx_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1 u_if.rx_valid = 1'b0;
    check_eq("calib_rx_ready", 128'(n_rxrdy - x0), 128'd0);
    check_eq("calib_no_cmd", 128'(n_cmd - c0), 128'd0);
    calib_done = 1'b1;

    // calib_done drops after the opcode: frame still completes
    txq.delete(); w0 = n_wr;
    send_frame(OP_WRITE, 32'h0000_0010, 128'h0123456789ABCDEF0011223344556677, 1'b1);
    wait_tx(1, 20, "cdrop_tx_cnt");
    check_eq("cdrop_reply", 128'(tx_byte(0)), 128'h4B);
    check_eq("cdrop_wr_data", last_wr_data, 128'h0123456789ABCDEF0011223344556677);
    calib_done = 1'b1;

    // Reset after 3 address bytes, then a full write with a 32-bit address
    txq.delete(); w0 = n_wr; c0 = n_cmd;
    send_byte(OP_WRITE);
    for (int i = 0; i < 3; i++) send_byte(8'h01);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rstmid_rx_ready", 128'(u_if.rx_ready), 128'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("rstmid_outs", 128'({u_if.tx_valid, u_if.p0_cmd_en, u_if.p0_wr_en, u_if.p0_rd_en,
                                  u_if.rx_ready}), 128'd0);
    check_eq("rstmid_buses", 128'({u_if.p0_cmd_byte_addr, u_if.tx_data}), 128'd0);
    check_eq("rstmid_wr_data", u_if.p0_wr_data, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    send_frame(OP_WRITE, 32'hC000_0347, 128'h101112131415161718191A1B1C1D1E1F, 1'b0);
    wait_tx(1, 20, "rstmid_tx_cnt");
    check_eq("rstmid_reply", 128'(tx_byte(0)), 128'h4B);
    check_eq("rstmid_addr", 128'(last_addr), 128'h340);
    check_eq("rstmid_wdata", last_wr_data, 128'h101112131415161718191A1B1C1D1E1F);
    check_eq("rstmid_counts", 128'({n_wr - w0, n_cmd - c0}), 128'({32'd1, 32'd1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
